// File: rtl/logic_ops_pkg.sv
// Shared encodings for the bit-serial logic sequencer: logic opcodes and
// sequencer states.
package logic_ops_pkg;

    typedef enum logic [2:0] {
        LOP_AND   = 3'd0,
        LOP_OR    = 3'd1,
        LOP_NOT_A = 3'd2,
        LOP_NOT_B = 3'd3,
        LOP_NAND  = 3'd4,
        LOP_NOR   = 3'd5,
        LOP_XOR   = 3'd6,
        LOP_XNOR  = 3'd7
    } lop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gate_select.sv
// Picks the gate-unit output named by the captured opcode (8:1 mux).
module gate_select
    import logic_ops_pkg::*;
(
    input  lop_e op,
    input  logic g_and,
    input  logic g_or,
    input  logic g_nota,
    input  logic g_notb,
    input  logic g_nand,
    input  logic g_nor,
    input  logic g_xor,
    input  logic g_xnor,
    output logic sel
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        sel = 1'b0;
        case (op)
            LOP_AND:   sel = g_and;
            LOP_OR:    sel = g_or;
            LOP_NOT_A: sel = g_nota;
            LOP_NOT_B: sel = g_notb;
            LOP_NAND:  sel = g_nand;
            LOP_NOR:   sel = g_nor;
            LOP_XOR:   sel = g_xor;
            LOP_XNOR:  sel = g_xnor;
            default:   sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/bitserial_logic_seq.sv
// Bit-serial sequencer around the external 1-bit gate unit: streams operand bits
// LSB first, collects the selected gate output, and returns a WIDTH-bit result.
module bitserial_logic_seq
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             g_and,
    input  logic             g_or,
    input  logic             g_nota,
    input  logic             g_notb,
    input  logic             g_nand,
    input  logic             g_nor,
    input  logic             g_xor,
    input  logic             g_xnor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lop_e             op_q, op_d;
    logic             valid_q, valid_d;
    logic             sel_bit;

    gate_select u_gate_select (
        .op     (op_q),
        .g_and  (g_and),
        .g_or   (g_or),
        .g_nota (g_nota),
        .g_notb (g_notb),
        .g_nand (g_nand),
        .g_nor  (g_nor),
        .g_xor  (g_xor),
        .g_xnor (g_xnor),
        .sel    (sel_bit)
    );

    // in_ready is held low for the whole reset pulse, not just until the first edge.
    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign gate_a     = (state_q == S_RUN) ? a_sh_q[0] : 1'b0;
    assign gate_b     = (state_q == S_RUN) ? b_sh_q[0] : 1'b0;
    assign out_valid  = valid_q;
    assign out_result = res_q;
    assign out_op     = op_q;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = in_a;
                    b_sh_d  = in_b;
                    op_d    = lop_e'(in_op);
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[cnt_q] = sel_bit;
                a_sh_d       = a_sh_q >> 1;
                b_sh_d       = b_sh_q >> 1;
                // The counter parks on the last index so it never wraps mid-operation.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= LOP_AND;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_bitserial_logic_seq.sv
// Scoreboard bench for bitserial_logic_seq: directed WIDTH=8 scenarios plus
// randomized WIDTH=2 and WIDTH=32 instances checked against a word-level model.
module tb_bitserial_logic_seq;
    import logic_ops_pkg::*;

    localparam int W = 8;
    localparam logic [7:0] SWEEP_EXP [8] = '{8'h24, 8'hBD, 8'h5A, 8'hC3,
                                             8'hDB, 8'h42, 8'h99, 8'h66};

    typedef struct {
        logic [63:0] res;
        logic [2:0]  op;
        logic [63:0] acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cyc = 64'd0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 64'd1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Word-level reference: the whole result at once, masked to the operand width.
    function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op);
        logic [63:0] r;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        r    = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~a;
            3'd3: r = ~b;
            3'd4: r = ~(a & b);
            3'd5: r = ~(a | b);
            3'd6: r = a ^ b;
            3'd7: r = ~(a ^ b);
            default: r = '0;
        endcase
        return r & mask;
    endfunction

    // ---------------- main WIDTH=8 instance ----------------
    logic         in_valid, in_ready, out_valid, out_ready, gate_a, gate_b;
    logic [W-1:0] in_a, in_b, out_result;
    logic [2:0]   in_op, out_op;

    bitserial_logic_seq #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .gate_a     (gate_a),
        .gate_b     (gate_b),
        .g_and      (gate_a & gate_b),
        .g_or       (gate_a | gate_b),
        .g_nota     (~gate_a),
        .g_notb     (~gate_b),
        .g_nand     (~(gate_a & gate_b)),
        .g_nor      (~(gate_a | gate_b)),
        .g_xor      (gate_a ^ gate_b),
        .g_xnor     (~(gate_a ^ gate_b)),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op)
    );

    exp_t        sb_q[$];
    exp_t        e_pop, e_new;
    logic        prev_valid = 1'b0;
    logic        stream_mode = 1'b0;
    logic        have_last = 1'b0;
    logic [63:0] last_acc = 64'd0;

    // Monitor: pushes on observed acceptance, compares on observed result handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                check("sb_entry_on_valid", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) check("latency", cyc - sb_q[0].acc, 64'(W));
            end
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
                check("sb_entry_on_handshake", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e_pop = sb_q.pop_front();
                    check("sb_result", 64'(out_result), e_pop.res);
                    check("sb_op", 64'(out_op), 64'(e_pop.op));
                end
            end
            if (!stream_mode) have_last = 1'b0;
            if (in_valid && in_ready) begin
                e_new.res = model(W, 64'(in_a), 64'(in_b), in_op);
                e_new.op  = in_op;
                e_new.acc = cyc + 64'd1;
                sb_q.push_back(e_new);
                if (stream_mode && have_last) check("stream_gap", e_new.acc - last_acc, 64'(W + 2));
                last_acc  = e_new.acc;
                have_last = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        bit done;
        done     = 1'b0;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("accept_in_time", 64'(done), 64'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < W + 6 && !out_valid; i++) tick();
        check("valid_in_time", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * W + 20 && !(in_ready && !out_valid); i++) tick();
        check("idle_in_time", 64'(in_ready && !out_valid), 64'd1);
    endtask

    // ---------------- randomized WIDTH=2 / WIDTH=32 instances ----------------
    logic par_go = 1'b0;

    for (genvar k = 0; k < 2; k++) begin : g_par
        localparam int PW   = (k == 0) ? 2 : 32;
        localparam int NOPS = 1000;

        logic          p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_gate_a, p_gate_b;
        logic [PW-1:0] p_in_a, p_in_b, p_out_result;
        logic [2:0]    p_in_op, p_out_op;
        exp_t          pq[$];
        exp_t          pe_pop, pe_new;
        int            max_cnt = 0;
        int            n_done = 0;
        bit            done_f = 1'b0;

        bitserial_logic_seq #(.WIDTH(PW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (p_in_valid),
            .in_ready   (p_in_ready),
            .in_a       (p_in_a),
            .in_b       (p_in_b),
            .in_op      (p_in_op),
            .gate_a     (p_gate_a),
            .gate_b     (p_gate_b),
            .g_and      (p_gate_a & p_gate_b),
            .g_or       (p_gate_a | p_gate_b),
            .g_nota     (~p_gate_a),
            .g_notb     (~p_gate_b),
            .g_nand     (~(p_gate_a & p_gate_b)),
            .g_nor      (~(p_gate_a | p_gate_b)),
            .g_xor      (p_gate_a ^ p_gate_b),
            .g_xnor     (~(p_gate_a ^ p_gate_b)),
            .out_valid  (p_out_valid),
            .out_ready  (p_out_ready),
            .out_result (p_out_result),
            .out_op     (p_out_op)
        );

        always @(negedge clk) begin
            if (rst) begin
                pq.delete();
            end else begin
                if (int'(u_dut.cnt_q) > max_cnt) max_cnt = int'(u_dut.cnt_q);
                if (p_out_valid && p_out_ready) begin
                    n_done++;
                    check($sformatf("par%0d_sb_entry", PW), 64'(pq.size() > 0), 64'd1);
                    if (pq.size() > 0) begin
                        pe_pop = pq.pop_front();
                        check($sformatf("par%0d_result", PW), 64'(p_out_result), pe_pop.res);
                        check($sformatf("par%0d_op", PW), 64'(p_out_op), 64'(pe_pop.op));
                    end
                end
                if (p_in_valid && p_in_ready) begin
                    pe_new.res = model(PW, 64'(p_in_a), 64'(p_in_b), p_in_op);
                    pe_new.op  = p_in_op;
                    pe_new.acc = cyc + 64'd1;
                    pq.push_back(pe_new);
                end
            end
        end

        initial begin
            int n_sent;
            bit acc;
            n_sent      = 0;
            p_in_valid  = 1'b0;
            p_in_a      = '0;
            p_in_b      = '0;
            p_in_op     = '0;
            p_out_ready = 1'b0;
            wait (par_go);
            @(posedge clk);
            #1;
            for (int t = 0; t < NOPS * (PW + 8) + 1000 && n_done < NOPS; t++) begin
                acc = p_in_valid && p_in_ready;
                @(posedge clk);
                #1;
                if (acc) begin
                    n_sent++;
                    p_in_valid = 1'b0;
                end
                if (!p_in_valid && n_sent < NOPS && $urandom_range(0, 3) != 0) begin
                    p_in_a     = PW'($urandom);
                    p_in_b     = PW'($urandom);
                    p_in_op    = 3'($urandom_range(0, 7));
                    p_in_valid = 1'b1;
                end
                p_out_ready = ($urandom_range(0, 3) != 0);
            end
            p_in_valid = 1'b0;
            check($sformatf("par%0d_ops_done", PW), 64'(n_done), 64'(NOPS));
            check($sformatf("par%0d_cnt_bound", PW), 64'(max_cnt <= PW - 1), 64'd1);
            done_f = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] a, b;
        logic [2:0]   op;
        logic [63:0]  bp_exp;
        bit           seen, acc;
        int           n_acc;

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_op", 64'(out_op), 64'd0);
        check("rst_gates", 64'({gate_a, gate_b}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Opcode sweep on the reference operands.
        for (int i = 0; i < 8; i++) begin
            send(8'hA5, 8'h3C, 3'(i));
            wait_valid();
            check($sformatf("sweep_result_op%0d", i), 64'(out_result), 64'(SWEEP_EXP[i]));
            check($sformatf("sweep_out_op%0d", i), 64'(out_op), 64'(i));
            tick();
        end

        // Bit ordering on the gate inputs.
        send(8'h01, 8'h80, 3'd6);
        for (int i = 0; i < W; i++) begin
            check($sformatf("order_gates_bit%0d", i), 64'({gate_a, gate_b}), 64'({i == 0, i == W - 1}));
            tick();
        end
        check("order_gates_done", 64'({gate_a, gate_b}), 64'd0);
        check("order_valid", 64'(out_valid), 64'd1);
        check("order_result", 64'(out_result), 64'h81);
        tick();
        check("order_gates_idle", 64'({gate_a, gate_b}), 64'd0);

        // Backpressure in DONE with new offers that must be ignored.
        out_ready = 1'b0;
        a  = W'($urandom);
        b  = W'($urandom);
        op = 3'($urandom_range(0, 7));
        bp_exp = model(W, 64'(a), 64'(b), op);
        send(a, b, op);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_op    = 3'($urandom_range(0, 7));
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_result", 64'(out_result), bp_exp);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset after bit 3 has been captured.
        send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_result", 64'(out_result), 64'd0);
        check("midrun_rst_ready", 64'(in_ready), 64'd0);
        check("midrun_rst_gates", 64'({gate_a, gate_b}), 64'd0);
        check("midrun_rst_op", 64'(out_op), 64'd0);
        repeat (2) tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            seen = seen | out_valid;
            tick();
        end
        check("midrun_no_valid", 64'(seen), 64'd0);
        send(8'hFF, 8'h0F, 3'd0);
        wait_valid();
        check("post_rst_and", 64'(out_result), 64'h0F);
        tick();

        // Streaming with offers held and results always accepted.
        stream_mode = 1'b1;
        out_ready   = 1'b1;
        in_a        = W'($urandom);
        in_b        = W'($urandom);
        in_op       = 3'($urandom_range(0, 7));
        in_valid    = 1'b1;
        n_acc       = 0;
        for (int t = 0; t < 30 * (W + 2) && n_acc < 20; t++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                n_acc++;
                in_a  = W'($urandom);
                in_b  = W'($urandom);
                in_op = 3'($urandom_range(0, 7));
            end
        end
        in_valid = 1'b0;
        check("stream_count", 64'(n_acc), 64'd20);
        wait_idle();
        stream_mode = 1'b0;
        tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        // Randomized runs on the narrow and wide instances.
        par_go = 1'b1;
        for (int i = 0; i < 90000 && !(g_par[0].done_f && g_par[1].done_f); i++) @(posedge clk);
        check("par_finished", 64'({g_par[0].done_f, g_par[1].done_f}), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
